// File: rtl/l1_param_tracker_pkg.sv
// Shared constants for the L1 parameter tracker: PLP field offsets, k_bch tables,
// FSM state encodings and the CRC-32 polynomial/seed.
package l1_param_tracker_pkg;

    localparam int PLP_STRIDE     = 89;
    localparam int OFF_PLP_ID     = 254;
    localparam int OFF_COD        = 290;
    localparam int OFF_FEC        = 297;
    localparam int OFF_MODE       = 339;
    localparam int OFF_NUM_BLOCKS = 493;
    localparam int T2_FRAMES_BYTE = 16;

    // Entry [cod] holds the BCH payload size; element 0 is the rightmost.
    localparam logic [5:0][15:0] KBCH_FEC0 = {16'd13152, 16'd12432, 16'd11712,
                                              16'd10632, 16'd9552,  16'd7032};
    localparam logic [5:0][15:0] KBCH_FEC1 = {16'd53840, 16'd51648, 16'd48408,
                                              16'd43040, 16'd38688, 16'd32208};

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_CRC_CHECK, ST_DECODE} state_t;

    typedef struct packed {
        logic [7:0]  plp_id;
        logic        hem;
        logic [9:0]  num_blocks;
        logic [15:0] k_bch;
        logic        err;
    } plp_param_t;

    // Returns {err, k_bch}; unsupported fec/cod yields k_bch 0 with err set.
    function automatic logic [16:0] kbch_lookup(input logic [1:0] fec, input logic [2:0] cod);
        logic [16:0] r;
        r = {1'b1, 16'd0};
        if (cod < 3'd6) begin
            if (fec == 2'd0)      r = {1'b0, KBCH_FEC0[cod]};
            else if (fec == 2'd1) r = {1'b0, KBCH_FEC1[cod]};
        end
        return r;
    endfunction

endpackage

// File: rtl/l1_crc32.sv
// Byte-wide CRC-32 (MSB first, no reflection, no final XOR); clr reseeds, and
// clr together with en folds the byte into a fresh seed.
module l1_crc32
    import l1_param_tracker_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            c = (c[31] ^ d[i]) ? ({c[30:0], 1'b0} ^ CRC_POLY) : {c[30:0], 1'b0};
        end
        return c;
    endfunction

    logic [31:0] seed;
    assign seed = clr ? CRC_INIT : crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   crc <= CRC_INIT;
        else if (en)  crc <= crc_byte(seed, data);
        else if (clr) crc <= CRC_INIT;
    end

endmodule

// File: rtl/l1_param_tracker.sv
// L1 block capture, per-PLP decode into shadow registers and frame-aligned commit.
// Optional CRC-32 trailer check when L1_CRC_CHECK_EN is defined.
module l1_param_tracker
    import l1_param_tracker_pkg::*;
#(
    parameter int L1_LEN_BYTES  = 80,
    parameter int MAX_PLP       = 2,
    parameter int PLP_LOOP_BITS = PLP_STRIDE,
    parameter int ADDR_W        = 7,
    parameter int PLP_SEL_W     = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [7:0]           L1_BYTE,
    input  logic                 L1_VALID,
    input  logic                 L1_SOP,
    input  logic                 L1_EOP,
    input  logic                 FRAME_START,
    input  logic [PLP_SEL_W-1:0] PLP_SEL,
    input  logic [ADDR_W-1:0]    L1_ADDRESS,
    output logic [7:0]           L1_DATA_OUT,
    output logic [7:0]           plp_id,
    output logic                 nm_or_hem,
    output logic [9:0]           plp_num_blocks,
    output logic [7:0]           num_t2_frames,
    output logic [15:0]          k_bch,
    output logic                 PARAMS_VALID,
    output logic                 COMMIT,
    output logic                 L1_ERR
);

    localparam int TOT_BITS = L1_LEN_BYTES * 8;
    localparam int IW       = $clog2(TOT_BITS);
    localparam int CW       = $clog2(L1_LEN_BYTES + 1);
    localparam int DW       = (MAX_PLP > 1) ? $clog2(MAX_PLP) : 1;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n, wr_addr;
    logic              wr_en, err_n, commit_n, dec_last, pend;
    logic [DW-1:0]     dec_idx;
    int                dec_base;
    logic [16:0]       dec_kb;

    logic [7:0]        stage [L1_LEN_BYTES];
    logic [7:0]        good  [L1_LEN_BYTES];
    logic [TOT_BITS-1:0] stage_flat;
    plp_param_t        shadow [MAX_PLP];
    plp_param_t        active [MAX_PLP];
    plp_param_t        dec_entry, sel_entry;
    logic [7:0]        shadow_t2, active_t2;

`ifdef L1_CRC_CHECK_EN
    logic [31:0] crc;
    logic        crc_en, crc_clr, crc_ok;
    localparam state_t ST_AFTER_CAPTURE = ST_CRC_CHECK;

    assign crc_en  = L1_VALID && ((state == ST_IDLE && L1_SOP) || state == ST_CAPTURE);
    assign crc_clr = crc_en && L1_SOP;
    // Folding the appended checksum through the CRC leaves a zero residue on a good block.
    assign crc_ok  = (crc == 32'd0);

    l1_crc32 u_crc (
        .clk  (CLK),
        .rst_n(RST_N),
        .clr  (crc_clr),
        .en   (crc_en),
        .data (L1_BYTE),
        .crc  (crc)
    );
`else
    localparam state_t ST_AFTER_CAPTURE = ST_DECODE;
`endif

    assign dec_last = (state == ST_DECODE) && (dec_idx == DW'(MAX_PLP - 1));
    assign commit_n = FRAME_START && pend && (state != ST_DECODE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr_en   = 1'b0;
        wr_addr = cnt;
        err_n   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (L1_VALID && L1_SOP) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    cnt_n   = CW'(1);
                    state_n = L1_EOP ? ST_IDLE : ST_CAPTURE;
                    err_n   = L1_EOP;
                end
            end
            ST_CAPTURE: begin
                if (L1_VALID) begin
                    if (L1_SOP) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        cnt_n   = CW'(1);
                        if (L1_EOP) begin
                            err_n   = 1'b1;
                            state_n = ST_IDLE;
                        end
                    end else if (cnt == CW'(L1_LEN_BYTES)) begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        wr_en = 1'b1;
                        cnt_n = cnt + CW'(1);
                        if (L1_EOP) begin
                            if (cnt_n == CW'(L1_LEN_BYTES)) begin
                                state_n = ST_AFTER_CAPTURE;
                            end else begin
                                err_n   = 1'b1;
                                state_n = ST_IDLE;
                            end
                        end
                    end
                end
            end
`ifdef L1_CRC_CHECK_EN
            ST_CRC_CHECK: begin
                if (crc_ok) begin
                    state_n = ST_DECODE;
                end else begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
`endif
            ST_DECODE: begin
                if (dec_last) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Bit 0 of the block is the MSB of byte 0.
    always_comb begin
        stage_flat = '0;
        for (int i = 0; i < L1_LEN_BYTES; i++) stage_flat[TOT_BITS-1-8*i -: 8] = stage[i];
    end

    function automatic logic [15:0] get_field(input logic [TOT_BITS-1:0] v, input int pos, input int w);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            if (k < w) r = {r[14:0], v[IW'(TOT_BITS - 1 - pos - k)]};
        end
        return r;
    endfunction

    assign dec_base = int'(dec_idx) * PLP_LOOP_BITS;
    assign dec_kb   = kbch_lookup(2'(get_field(stage_flat, dec_base + OFF_FEC, 2)),
                                  3'(get_field(stage_flat, dec_base + OFF_COD, 3)));

    always_comb begin
        dec_entry.plp_id     = 8'(get_field(stage_flat, dec_base + OFF_PLP_ID, 8));
        dec_entry.hem        = 1'(get_field(stage_flat, dec_base + OFF_MODE, 1));
        dec_entry.num_blocks = 10'(get_field(stage_flat, dec_base + OFF_NUM_BLOCKS, 10));
        dec_entry.k_bch      = dec_kb[15:0];
        dec_entry.err        = dec_kb[16];
    end

    always_ff @(posedge CLK) begin
        if (wr_en) stage[wr_addr] <= L1_BYTE;
        if (state == ST_DECODE) shadow[dec_idx] <= dec_entry;
        if (dec_last) begin
            shadow_t2 <= stage[T2_FRAMES_BYTE];
            for (int i = 0; i < L1_LEN_BYTES; i++) good[i] <= stage[i];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            dec_idx      <= '0;
            pend         <= 1'b0;
            active       <= '{default: '0};
            active_t2    <= '0;
            PARAMS_VALID <= 1'b0;
            COMMIT       <= 1'b0;
            L1_ERR       <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            L1_ERR  <= err_n;
            COMMIT  <= commit_n;
            dec_idx <= (state == ST_DECODE && !dec_last) ? dec_idx + DW'(1) : '0;
            // A fresh decode invalidates any shadow set still waiting for a frame boundary.
            if (dec_last)
                pend <= 1'b1;
            else if ((state == ST_DECODE && dec_idx == '0) || commit_n)
                pend <= 1'b0;
            if (commit_n) begin
                active       <= shadow;
                active_t2    <= shadow_t2;
                PARAMS_VALID <= 1'b1;
            end
        end
    end

    assign sel_entry = (int'(PLP_SEL) < MAX_PLP) ? active[PLP_SEL] : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            plp_id         <= '0;
            nm_or_hem      <= 1'b0;
            plp_num_blocks <= '0;
            k_bch          <= '0;
            num_t2_frames  <= '0;
            L1_DATA_OUT    <= '0;
        end else begin
            plp_id         <= sel_entry.plp_id;
            nm_or_hem      <= sel_entry.hem;
            plp_num_blocks <= sel_entry.num_blocks;
            k_bch          <= sel_entry.err ? 16'd0 : sel_entry.k_bch;
            num_t2_frames  <= active_t2;
            L1_DATA_OUT    <= (int'(L1_ADDRESS) < L1_LEN_BYTES) ? good[L1_ADDRESS] : 8'd0;
        end
    end

endmodule

// File: tb/tb_l1_param_tracker.sv
// Directed bench for l1_param_tracker: length checks, decode, commit atomicity,
// readback and reset; CRC trailer cases when L1_CRC_CHECK_EN is defined.
module tb_l1_param_tracker;

    localparam int LEN = 80;
`ifdef L1_CRC_CHECK_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] l1_byte;
    logic       l1_valid, l1_sop, l1_eop, frame_start;
    logic [0:0] plp_sel;
    logic [6:0] l1_address;
    logic [7:0] l1_data_out, plp_id, num_t2_frames;
    logic       nm_or_hem, params_valid, commit, l1_err;
    logic [9:0] plp_num_blocks;
    logic [15:0] k_bch;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] blk [LEN+1];

    always #5 clk = ~clk;

    l1_param_tracker dut (
        .CLK(clk), .RST_N(rst_n), .L1_BYTE(l1_byte), .L1_VALID(l1_valid),
        .L1_SOP(l1_sop), .L1_EOP(l1_eop), .FRAME_START(frame_start),
        .PLP_SEL(plp_sel), .L1_ADDRESS(l1_address), .L1_DATA_OUT(l1_data_out),
        .plp_id(plp_id), .nm_or_hem(nm_or_hem), .plp_num_blocks(plp_num_blocks),
        .num_t2_frames(num_t2_frames), .k_bch(k_bch), .PARAMS_VALID(params_valid),
        .COMMIT(commit), .L1_ERR(l1_err)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_blk();
        for (int i = 0; i <= LEN; i++) blk[i] = 8'h00;
    endtask

    task automatic put(input int pos, input int w, input logic [15:0] v);
        for (int k = 0; k < w; k++) blk[(pos + k) / 8][7 - ((pos + k) % 8)] = v[w - 1 - k];
    endtask

    task automatic set_plp(input int n, input int id, input int fec, input int cod,
                           input int hem, input int nb);
        int b;
        b = n * 89;
        put(254 + b, 8, 16'(id));
        put(290 + b, 3, 16'(cod));
        put(297 + b, 2, 16'(fec));
        put(339 + b, 1, 16'(hem));
        put(493 + b, 10, 16'(nb));
    endtask

`ifdef L1_CRC_CHECK_EN
    function automatic logic [31:0] crc_of(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++)
            for (int b = 7; b >= 0; b--)
                c = (c[31] ^ blk[i][b]) ? ({c[30:0], 1'b0} ^ 32'h04C1_1DB7) : {c[30:0], 1'b0};
        return c;
    endfunction
`endif

    task automatic seal();
`ifdef L1_CRC_CHECK_EN
        logic [31:0] c;
        c = crc_of(LEN - 4);
        blk[LEN-4] = c[31:24];
        blk[LEN-3] = c[23:16];
        blk[LEN-2] = c[15:8];
        blk[LEN-1] = c[7:0];
`endif
    endtask

    task automatic send(input int n, input bit eop);
        for (int i = 0; i < n; i++) begin
            l1_valid = 1'b1;
            l1_sop   = (i == 0);
            l1_eop   = eop && (i == n - 1);
            l1_byte  = blk[i];
            tick();
        end
        l1_valid = 1'b0;
        l1_sop   = 1'b0;
        l1_eop   = 1'b0;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; l1_byte = '0; l1_valid = 1'b0; l1_sop = 1'b0; l1_eop = 1'b0;
        frame_start = 1'b0; plp_sel = 1'b0; l1_address = '0;
        tick(3);
        chk("rst_plp_id", 32'(plp_id), 0);
        chk("rst_k_bch", 32'(k_bch), 0);
        chk("rst_params_valid", 32'(params_valid), 0);
        chk("rst_commit", 32'(commit), 0);
        chk("rst_l1_err", 32'(l1_err), 0);
        chk("rst_data_out", 32'(l1_data_out), 0);
        rst_n = 1'b1;
        tick();

        // Good block, PLP0 fec=1 cod=2
        clr_blk(); set_plp(0, 5, 1, 2, 0, 200); blk[16] = 8'd4; seal();
        send(LEN, 1'b1);
        chk("t1_no_err", 32'(l1_err), 0);
        tick(2 + XTRA);
        fs();
        chk("t1_commit", 32'(commit), 1);
        tick();
        chk("t1_commit_pulse", 32'(commit), 0);
        chk("t1_plp_id", 32'(plp_id), 5);
        chk("t1_k_bch", 32'(k_bch), 43040);
        chk("t1_num_blocks", 32'(plp_num_blocks), 200);
        chk("t1_t2_frames", 32'(num_t2_frames), 4);
        chk("t1_params_valid", 32'(params_valid), 1);
        chk("t1_nm", 32'(nm_or_hem), 0);
        plp_sel = 1'b1; tick();
        chk("t1_plp1_k_bch", 32'(k_bch), 7032);
        plp_sel = 1'b0;

        l1_address = 7'd16; tick();
        chk("rd_byte16", 32'(l1_data_out), 4);
        l1_address = 7'd32; tick();
        chk("rd_byte32", 32'(l1_data_out), 32'h14);
        l1_address = 7'd100; tick();
        chk("rd_out_of_range", 32'(l1_data_out), 0);

        // Short block (EOP at 79 bytes)
        clr_blk(); set_plp(0, 8'h33, 1, 2, 0, 200); seal();
        send(LEN - 1, 1'b1);
        chk("short_err", 32'(l1_err), 1);
        tick();
        chk("short_err_pulse", 32'(l1_err), 0);
        fs();
        chk("short_no_commit", 32'(commit), 0);
        tick();
        chk("short_plp_id", 32'(plp_id), 5);

        // Overflow: 81 bytes, no EOP
        send(LEN + 1, 1'b0);
        chk("ovf_err", 32'(l1_err), 1);
        tick();
        fs();
        chk("ovf_no_commit", 32'(commit), 0);
        tick();
        chk("ovf_plp_id", 32'(plp_id), 5);
        chk("ovf_params_valid", 32'(params_valid), 1);

        // Second PLP: fec=0 cod=5 HEM
        clr_blk(); set_plp(0, 5, 1, 2, 0, 200); set_plp(1, 8'h22, 0, 5, 1, 3); blk[16] = 8'd4; seal();
        send(LEN, 1'b1);
        tick(2 + XTRA);
        plp_sel = 1'b1;
        fs();
        chk("t3_commit", 32'(commit), 1);
        tick();
        chk("t3_k_bch", 32'(k_bch), 13152);
        chk("t3_hem", 32'(nm_or_hem), 1);
        chk("t3_plp_id", 32'(plp_id), 32'h22);
        chk("t3_num_blocks", 32'(plp_num_blocks), 3);

        // FRAME_START on the last decode cycle must not commit; cod=7 on PLP1
        clr_blk(); set_plp(1, 8'h22, 0, 7, 1, 3); seal();
        send(LEN, 1'b1);
        tick(1 + XTRA);
        fs();
        chk("atom_no_commit", 32'(commit), 0);
        tick();
        chk("atom_still_no_commit", 32'(commit), 0);
        chk("atom_old_k_bch", 32'(k_bch), 13152);
        fs();
        chk("atom_commit", 32'(commit), 1);
        tick();
        chk("cod7_k_bch", 32'(k_bch), 0);
        chk("cod7_plp_id", 32'(plp_id), 32'h22);

        // Two decodes before one frame boundary: last writer wins
        clr_blk(); set_plp(0, 8'h11, 1, 1, 0, 10); seal();
        send(LEN, 1'b1);
        tick(2 + XTRA);
        clr_blk(); set_plp(0, 8'h44, 0, 1, 0, 20); blk[16] = 8'd9; seal();
        send(LEN, 1'b1);
        tick(2 + XTRA);
        plp_sel = 1'b0;
        fs();
        chk("lww_commit", 32'(commit), 1);
        tick();
        chk("lww_plp_id", 32'(plp_id), 32'h44);
        chk("lww_k_bch", 32'(k_bch), 9552);
        chk("lww_num_blocks", 32'(plp_num_blocks), 20);
        chk("lww_t2_frames", 32'(num_t2_frames), 9);

        // Reset in the middle of a capture
        clr_blk(); set_plp(0, 8'h77, 1, 4, 0, 1); seal();
        send(40, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_plp_id", 32'(plp_id), 0);
        chk("mid_rst_k_bch", 32'(k_bch), 0);
        chk("mid_rst_params_valid", 32'(params_valid), 0);
        chk("mid_rst_t2_frames", 32'(num_t2_frames), 0);
        chk("mid_rst_data_out", 32'(l1_data_out), 0);
        tick();
        rst_n = 1'b1;
        tick();
        clr_blk(); set_plp(0, 8'h5A, 1, 0, 0, 512); blk[16] = 8'd7; seal();
        send(LEN, 1'b1);
        tick(2 + XTRA);
        fs();
        chk("post_rst_commit", 32'(commit), 1);
        tick();
        chk("post_rst_plp_id", 32'(plp_id), 32'h5A);
        chk("post_rst_k_bch", 32'(k_bch), 32208);
        chk("post_rst_num_blocks", 32'(plp_num_blocks), 512);
        chk("post_rst_t2_frames", 32'(num_t2_frames), 7);
        chk("post_rst_params_valid", 32'(params_valid), 1);

`ifdef L1_CRC_CHECK_EN
        // Corrupted payload bit fails the CRC trailer
        clr_blk(); set_plp(0, 8'h66, 1, 3, 0, 30); seal();
        blk[10] = blk[10] ^ 8'h08;
        send(LEN, 1'b1);
        tick();
        chk("crc_bad_err", 32'(l1_err), 1);
        tick(2);
        fs();
        chk("crc_bad_no_commit", 32'(commit), 0);
        tick();
        chk("crc_bad_plp_id", 32'(plp_id), 32'h5A);
        clr_blk(); set_plp(0, 8'h66, 1, 3, 0, 30); seal();
        send(LEN, 1'b1);
        tick(2 + XTRA);
        fs();
        chk("crc_good_commit", 32'(commit), 1);
        tick();
        chk("crc_good_plp_id", 32'(plp_id), 32'h66);
        chk("crc_good_k_bch", 32'(k_bch), 48408);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
